// File: rtl/updown_pkg.sv
// Shared types and constants for the up/down sweep controller.
package updown_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    SEEK,
    UP,
    HOLD_HI,
    DOWN,
    HOLD_LO,
    DONE
  } state_t;

endpackage

// File: rtl/dwell_timer.sv
// Load-and-count-down timer; tc is high while the count sits at zero.
module dwell_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] count;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Drives an up/down counter as a triangle wave between latched bounds,
// dwelling at each bound and counting completed sweeps.
module updown_sweep_ctrl
  import updown_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int DWELL_W = 8,
  parameter int SWEEP_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   lo_bound,
  input  logic [WIDTH-1:0]   hi_bound,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [SWEEP_W-1:0] n_sweeps,
  input  logic [WIDTH-1:0]   cnt_val,
  output logic               cnt_en,
  output logic               up_down,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic [SWEEP_W-1:0] sweep_cnt
);

  state_t             state, state_next;
  logic [WIDTH-1:0]   lo_q, hi_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [SWEEP_W-1:0] n_sweeps_q;
  logic [SWEEP_W-1:0] sweep_cnt_q;
  logic [SWEEP_W-1:0] sweep_plus;
  logic               cfg_err_q;

  logic accept, reject, sweep_inc, timer_load, timer_tc;

  assign sweep_plus = sweep_cnt_q + 1'b1;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_en     = 1'b0;
    up_down    = DIR_UP;
    accept     = 1'b0;
    reject     = 1'b0;
    sweep_inc  = 1'b0;
    timer_load = 1'b0;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (lo_bound < hi_bound) begin
            accept     = 1'b1;
            state_next = SEEK;
          end else begin
            reject = 1'b1;
          end
        end
      end
      SEEK: begin
        up_down = (cnt_val < lo_q) ? DIR_UP : DIR_DOWN;
        cnt_en  = (cnt_val != lo_q);
        if (cnt_val == lo_q) state_next = UP;
      end
      UP: begin
        up_down = DIR_UP;
        cnt_en  = (cnt_val != hi_q);
        if (cnt_val == hi_q) begin
          state_next = HOLD_HI;
          timer_load = 1'b1;
        end
      end
      HOLD_HI: begin
        if (timer_tc) state_next = DOWN;
      end
      DOWN: begin
        up_down = DIR_DOWN;
        cnt_en  = (cnt_val != lo_q);
        if (cnt_val == lo_q) begin
          state_next = HOLD_LO;
          timer_load = 1'b1;
        end
      end
      HOLD_LO: begin
        if (timer_tc) begin
          sweep_inc = 1'b1;
          // n_sweeps of zero means run until abort.
          if (n_sweeps_q != '0 && sweep_plus == n_sweeps_q) state_next = DONE;
          else                                              state_next = UP;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Abort overrides everything outside IDLE, including the step enable this cycle.
    if (abort && state != IDLE) begin
      state_next = IDLE;
      cnt_en     = 1'b0;
      sweep_inc  = 1'b0;
      timer_load = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      dwell_q     <= '0;
      n_sweeps_q  <= '0;
      sweep_cnt_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state     <= state_next;
      cfg_err_q <= reject;
      if (accept) begin
        lo_q        <= lo_bound;
        hi_q        <= hi_bound;
        dwell_q     <= dwell;
        n_sweeps_q  <= n_sweeps;
        sweep_cnt_q <= '0;
      end else if (sweep_inc) begin
        sweep_cnt_q <= sweep_plus;
      end
    end
  end

  dwell_timer #(.W(DWELL_W)) u_dwell_timer (
    .clk      (clk),
    .rst_n    (reset),
    .load     (timer_load),
    .load_val (dwell_q),
    .en       (state == HOLD_HI || state == HOLD_LO),
    .tc       (timer_tc)
  );

  assign busy      = (state != IDLE);
  assign done      = (state == DONE) && !abort;
  assign cfg_err   = cfg_err_q;
  assign sweep_cnt = sweep_cnt_q;

endmodule
